// File: rtl/capture_pkg.sv
// Shared types for the multi-channel ADC capture sequencer.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_EMPTY = 3'd1,
        ARMED      = 3'd2,
        CAPTURE    = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'd0,
        EXTERNAL  = 2'd1,
        RISING    = 2'd2,
        FALLING   = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/trig_detect.sv
// Trigger detector: selects one channel, remembers the previous armed sample,
// and flags a trigger according to the selected mode.
module trig_detect
    import capture_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DW   = 16,
    parameter int CH_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                armed,
    input  logic [NCH*DW-1:0]   adc_data,
    input  logic                adc_valid,
    input  logic                trig_ext,
    input  logic [1:0]          mode,
    input  logic [CH_W-1:0]     ch,
    input  logic [DW-1:0]       level,
    output logic                hit
);

    logic signed [DW-1:0] cur;
    logic signed [DW-1:0] prev;
    logic signed [DW-1:0] lvl;
    logic                 prev_valid;

    assign lvl = level;

    always_comb begin
        cur = '0;
        for (int k = 0; k < NCH; k++)
            if (ch == CH_W'(k)) cur = adc_data[k*DW +: DW];
    end

    // prev_valid drops whenever we are not armed, so each arming starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (!armed) begin
            prev_valid <= 1'b0;
        end else if (adc_valid) begin
            prev       <= cur;
            prev_valid <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        case (trig_mode_t'(mode))
            IMMEDIATE: hit = adc_valid;
            EXTERNAL:  hit = adc_valid && trig_ext;
            RISING:    hit = adc_valid && prev_valid && (prev <  lvl) && (cur >= lvl);
            FALLING:   hit = adc_valid && prev_valid && (prev >= lvl) && (cur <  lvl);
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/capture_sequencer.sv
// Armed, triggered, decimating record capture from NCH ADC channels into the
// width-converter FIFO, with abort and sticky overflow reporting.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int CNT_W = 24,
    parameter int DEC_W = 8,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   adc_data,
    input  logic                adc_valid,
    input  logic                arm,
    input  logic                abort,
    input  logic [1:0]          trig_mode,
    input  logic                trig_ext,
    input  logic [CH_W-1:0]     trig_ch,
    input  logic [DW-1:0]       trig_level,
    input  logic [CNT_W-1:0]    rec_len,
    input  logic [DEC_W-1:0]    decim,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                wr_en,
    output logic [NCH*DW-1:0]   dout,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    sample_cnt
);

    state_t            state_q, state_n;
    logic [1:0]        mode_l;
    logic [CH_W-1:0]   ch_l;
    logic [DW-1:0]     level_l;
    logic [CNT_W-1:0]  len_l;
    logic [DEC_W-1:0]  decim_l;
    logic [DEC_W-1:0]  dec_q, dec_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [NCH*DW-1:0] dout_n;
    logic              wr_n, done_n, ovf_n, load, produce, hit;

    trig_detect #(.NCH(NCH), .DW(DW), .CH_W(CH_W)) u_trig (
        .clk       (clk),
        .rst       (rst),
        .armed     (state_q == ARMED),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .trig_ext  (trig_ext),
        .mode      (mode_l),
        .ch        (ch_l),
        .level     (level_l),
        .hit       (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        wr_n    = 1'b0;
        done_n  = 1'b0;
        dout_n  = dout;
        ovf_n   = overflow;
        cnt_n   = sample_cnt;
        dec_n   = dec_q;
        load    = 1'b0;
        produce = 1'b0;

        case (state_q)
            IDLE: if (arm) begin
                load  = 1'b1;
                ovf_n = 1'b0;
                cnt_n = '0;
                if (rec_len == '0) done_n  = 1'b1;
                else               state_n = WAIT_EMPTY;
            end
            WAIT_EMPTY: if (fifo_empty) state_n = ARMED;
            ARMED:      if (hit) produce = 1'b1;
            CAPTURE: if (adc_valid) begin
                if (dec_q == '0) produce = 1'b1;
                else             dec_n   = dec_q - DEC_W'(1);
            end
            default: state_n = IDLE;
        endcase

        // A dropped word still advances the count so the record keeps its span
        if (produce) begin
            dec_n = decim_l;
            cnt_n = sample_cnt + CNT_W'(1);
            if (fifo_full) begin
                ovf_n = 1'b1;
            end else begin
                wr_n   = 1'b1;
                dout_n = adc_data;
            end
            if (cnt_n == len_l) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end else begin
                state_n = CAPTURE;
            end
        end

        if (abort) begin
            state_n = IDLE;
            wr_n    = 1'b0;
            done_n  = 1'b0;
            load    = 1'b0;
            dout_n  = dout;
            ovf_n   = overflow;
            cnt_n   = sample_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            dout       <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
            dec_q      <= '0;
            mode_l     <= '0;
            ch_l       <= '0;
            level_l    <= '0;
            len_l      <= '0;
            decim_l    <= '0;
        end else begin
            wr_en      <= wr_n;
            dout       <= dout_n;
            done       <= done_n;
            overflow   <= ovf_n;
            sample_cnt <= cnt_n;
            dec_q      <= dec_n;
            if (load) begin
                mode_l  <= trig_mode;
                ch_l    <= trig_ch;
                level_l <= trig_level;
                len_l   <= rec_len;
                decim_l <= decim;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: trigger modes, decimation, overflow,
// FIFO drain wait, abort, zero-length records and async reset.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] adc_data;
    logic        adc_valid, arm, abort, trig_ext, fifo_full, fifo_empty;
    logic [1:0]  trig_mode, trig_ch;
    logic [15:0] trig_level;
    logic [23:0] rec_len;
    logic [7:0]  decim;
    logic        wr_en, busy, done, overflow;
    logic [63:0] dout;
    logic [2:0]  state;
    logic [23:0] sample_cnt;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    capture_sequencer dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_ext(trig_ext),
        .trig_ch(trig_ch), .trig_level(trig_level), .rec_len(rec_len),
        .decim(decim), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .wr_en(wr_en), .dout(dout), .busy(busy), .done(done),
        .overflow(overflow), .state(state), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int mode, input int ch, input int lvl, input int len, input int dec);
        trig_mode  = mode[1:0];
        trig_ch    = ch[1:0];
        trig_level = lvl[15:0];
        rec_len    = len[23:0];
        decim      = dec[7:0];
        arm        = 1'b1;
        step();
        arm        = 1'b0;
    endtask

    initial begin
        int v, nw;
        logic exp_wr, seen_wr;

        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mode = '0; trig_ext = 1'b0; trig_ch = '0; trig_level = '0;
        rec_len = '0; decim = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_wr", 64'(wr_en), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_ovf", {62'd0, done, overflow}, 64'd0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Immediate mode, 8 words, no decimation
        adc_valid = 1'b1;
        do_arm(0, 0, 0, 8, 0);
        chk("imm_wait_state", 64'(state), 64'd1);
        chk("imm_busy", 64'(busy), 64'd1);
        step();
        chk("imm_armed_state", 64'(state), 64'd2);
        for (int i = 0; i < 8; i++) begin
            adc_data = pk(i, i + 16, i + 32, i + 48);
            step();
            chk("imm_wr", 64'(wr_en), 64'd1);
            chk("imm_dout", dout, pk(i, i + 16, i + 32, i + 48));
            chk("imm_cnt", 64'(sample_cnt), 64'(i + 1));
            chk("imm_done", 64'(done), (i == 7) ? 64'd1 : 64'd0);
        end
        chk("imm_idle", 64'(state), 64'd0);
        adc_data = pk(8, 8, 8, 8);
        step();
        chk("imm_no_more_wr", 64'(wr_en), 64'd0);
        chk("imm_done_clr", 64'(done), 64'd0);

        // Rising level on ch2, threshold 100, ramp 90,95,100,105
        do_arm(2, 2, 100, 2, 0);
        step();
        adc_data = pk(0, 0, 90, 0);  step();
        chk("rise_90", 64'(wr_en), 64'd0);
        adc_data = pk(0, 0, 95, 0);  step();
        chk("rise_95", 64'(wr_en), 64'd0);
        adc_data = pk(0, 0, 100, 0); step();
        chk("rise_100_wr", 64'(wr_en), 64'd1);
        chk("rise_100_dout", dout, pk(0, 0, 100, 0));
        adc_data = pk(0, 0, 105, 0); step();
        chk("rise_105_dout", dout, pk(0, 0, 105, 0));
        chk("rise_done", 64'(done), 64'd1);
        chk("rise_idle", 64'(state), 64'd0);

        // Ramp already above level from the first armed sample never triggers
        do_arm(2, 2, 100, 2, 0);
        step();
        seen_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adc_data = pk(0, 0, 110 + 10 * i, 0);
            step();
            seen_wr |= wr_en;
        end
        chk("rise_high_nowr", 64'(seen_wr), 64'd0);
        chk("rise_high_armed", 64'(state), 64'd2);
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        chk("armed_abort_idle", 64'(state), 64'd0);

        // Decimate by 4, rec_len 4, valid every other cycle
        do_arm(0, 0, 0, 4, 3);
        step();
        v = 0; nw = 0;
        for (int c = 0; c < 25; c++) begin
            adc_valid = (c % 2 == 0);
            adc_data  = adc_valid ? pk(v, v, v, v) : pk(999, 999, 999, 999);
            exp_wr    = adc_valid && (v % 4 == 0) && (nw < 4);
            step();
            chk("dec_wr", 64'(wr_en), 64'(exp_wr));
            if (exp_wr) begin
                chk("dec_dout", dout, pk(v, v, v, v));
                nw++;
            end
            if (adc_valid) v++;
        end
        chk("dec_idle", 64'(state), 64'd0);
        chk("dec_cnt", 64'(sample_cnt), 64'd4);

        // FIFO full during words 2 and 3 of 6
        adc_valid = 1'b1;
        do_arm(0, 0, 0, 6, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            fifo_full = (i == 2 || i == 3);
            adc_data  = pk(i, i, i, i);
            step();
            chk("full_wr", 64'(wr_en), (i == 2 || i == 3) ? 64'd0 : 64'd1);
            chk("full_cnt", 64'(sample_cnt), 64'(i + 1));
            chk("full_ovf", 64'(overflow), (i >= 2) ? 64'd1 : 64'd0);
        end
        chk("full_done", 64'(done), 64'd1);
        fifo_full = 1'b0;
        repeat (3) step();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Arm while FIFO not drained: holds in WAIT_EMPTY
        fifo_empty = 1'b0;
        do_arm(0, 0, 0, 3, 0);
        chk("arm_clears_ovf", 64'(overflow), 64'd0);
        seen_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen_wr |= wr_en;
        end
        chk("wait_state", 64'(state), 64'd1);
        chk("wait_nowr", 64'(seen_wr), 64'd0);
        fifo_empty = 1'b1;
        step();
        chk("wait_to_armed", 64'(state), 64'd2);
        adc_data = pk(7, 7, 7, 7);
        step();
        chk("cap_word0", 64'(wr_en), 64'd1);

        // Abort mid-capture together with arm
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        chk("abort_idle", 64'(state), 64'd0);
        chk("abort_wr", 64'(wr_en), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        step();
        chk("abort_stays_idle", 64'(state), 64'd0);

        // Zero-length record
        do_arm(0, 0, 0, 0, 0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_wr", 64'(wr_en), 64'd0);
        chk("zero_idle", 64'(state), 64'd0);
        step();
        chk("zero_done_pulse", 64'(done), 64'd0);

        // Async reset in the middle of a record
        do_arm(0, 0, 0, 8, 0);
        step();
        step();
        step();
        chk("pre_rst_wr", 64'(wr_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_wr", 64'(wr_en), 64'd0);
        chk("arst_dout", dout, 64'd0);
        chk("arst_flags", {61'd0, busy, done, overflow}, 64'd0);
        chk("arst_cnt", 64'(sample_cnt), 64'd0);
        #1 rst = 1'b0;
        step();
        chk("post_rst_idle", 64'(state), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
